link_bist_16b20b: RTL and testbench
===================================

Name: link_bist_16b20b

Overview:
- Parametrised built-in self-test for the 8b/10b-based multi-lane link (LANES byte lanes, 10 bits per lane after encoding).
- Generator side: produces a K28.5 alignment preamble, then PRBS-15 payload words with periodic comma insertion and per-lane K flags; its output feeds the encoder.
- Checker side: consumes the decoder's data, K flags and error flags; acquires lock, compares against a local PRBS replica and counts errors.
- Replaces hand-written loopback stimulus and scales the lane count beyond two.

Parameters:
- LANES, 2: byte lanes per word; DW = 8*LANES (derived, not overridable).
- ALIGN_LEN, 16: comma words sent in the ALIGN state (>=1).
- COMMA_PERIOD, 64: one comma word inserted after every COMMA_PERIOD payload words (>=2).
- LOSS_THRESH, 4: consecutive bad words that drop lock (>=1).
- CNT_W, 16: width of the error and word counters.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: level; generator runs while high.
- tx_ready, input, 1: encoder accepts the word this cycle.
- tx_data, output, DW: word to the encoder; lane i = bits [8i+7:8i].
- tx_k, output, LANES: per-lane K flag.
- tx_valid, output, 1: tx_data/tx_k valid.
- rx_valid, input, 1: decoder word valid.
- rx_data, input, DW: decoded word.
- rx_k, input, LANES: decoded K flags.
- rx_code_err, input, LANES: per-lane code error.
- rx_disp_err, input, LANES: per-lane disparity error.
- clr_cnt, input, 1: synchronous clear of the counters.
- locked, output, 1: checker in LOCKED.
- err_cnt, output, CNT_W: erroneous words, saturating.
- word_cnt, output, CNT_W: payload words checked, saturating.

Behaviour:
- Reset (rst=0, asynchronous): both FSMs enter IDLE/SEARCH; LFSRs = 15'h7FFF; tx_valid=0; tx_data=0; tx_k=0; locked=0; err_cnt=0; word_cnt=0; all internal counters=0.
- PRBS-15, polynomial x^15+x^14+1, Fibonacci form:
  - new = s[14]^s[13]; s <= {s[13:0], new}.
  - Each payload word takes DW successive new bits; first bit -> tx_data[DW-1].
  - From seed 7FFF the first 16-bit word is 16'h0002.
- Generator FSM: IDLE, ALIGN, DATA.
  - IDLE: tx_valid=0. start=1 -> ALIGN, LFSR := seed.
  - ALIGN: tx_data = 8'hBC in every lane, tx_k = all ones, tx_valid=1. Advances only on tx_valid&tx_ready. After ALIGN_LEN accepted words -> DATA.
  - DATA: tx_valid=1; tx_k=0; tx_data = current PRBS word. On acceptance the LFSR advances DW steps and the payload counter increments.
  - When the payload counter reaches COMMA_PERIOD, the next presented word is a comma word (all lanes BC, K set); the LFSR holds and the payload counter clears on its acceptance.
  - start=0 in ALIGN or DATA: the current word completes if already accepted, then -> IDLE next cycle; tx_valid=0 from that cycle.
- Outputs are registered, one-cycle latency from state/LFSR to port. tx_data and tx_k hold stable while tx_valid=1 and tx_ready=0.
- Checker FSM: SEARCH, LOCKED. It acts only on rx_valid=1.
  - SEARCH: an all-comma word (rx_k all ones, all lanes BC, no error flags) sets the seen_comma flag and loads LFSR := seed. The first subsequent non-K word with seen_comma=1 is compared -> LOCKED.
  - SEARCH: any other word clears seen_comma. No counting occurs in SEARCH.
  - LOCKED, comma word: skipped; LFSR holds; word_cnt unchanged.
  - LOCKED, non-comma word: compared with the PRBS word; LFSR advances DW steps; word_cnt+1.
  - A word is bad if the data mismatches, any rx_k bit is set without being a full comma word, or any rx_code_err/rx_disp_err bit is set. This applies to comma words too. A bad word gives err_cnt+1 and consec+1; a good word clears consec.
  - consec reaching LOSS_THRESH -> SEARCH; locked=0 the next cycle; seen_comma=0.
- The transition word (the first compared word in SEARCH) is counted like a LOCKED word.
- Counters saturate at all ones. clr_cnt zeroes err_cnt, word_cnt and consec; it wins over a simultaneous increment. It does not change the state.
- locked is registered: high the cycle after entering LOCKED.
- rx and tx sides are independent. Simultaneous events on both sides in one cycle are legal.

Test Plan:
- Reset/idle: rst=0 then 1, start=0 for 10 cycles -> tx_valid=0, locked=0, err_cnt=0, word_cnt=0.
- Alignment, LANES=2, tx_ready=1, tx looped to rx: start=1 -> exactly 16 words of 16'hBCBC with tx_k=2'b11, then first payload word 16'h0002 with tx_k=0. locked=1 one cycle after that word is received; err_cnt=0.
- Backpressure and comma insertion: tx_ready toggled randomly over 200 payload words -> no word lost or repeated; a BCBC/K=11 word after every 64 payload words; word_cnt=200; err_cnt=0.
- Error injection: flip bit 0 of one payload word -> err_cnt=1, locked stays 1. Assert rx_disp_err[1] for one word -> err_cnt=2.
- Loss of lock: corrupt 4 consecutive payload words -> locked=0 after the 4th; err_cnt=4. Resume with a realign (start low then high) -> relock; no further increments.
- Saturation/clear at CNT_W=4: 20 bad words -> err_cnt=4'hF. clr_cnt pulsed together with a bad word -> err_cnt=0. Reset mid-DATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/link_bist_16b20b.sv
// Built-in self-test for the multi-lane 8b/10b link: a K28.5/PRBS-15 pattern generator
// on the encoder side and a lock/compare/count checker on the decoder side.
module link_bist_16b20b #(
  parameter int LANES        = 2,
  parameter int ALIGN_LEN    = 16,
  parameter int COMMA_PERIOD = 64,
  parameter int LOSS_THRESH  = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tx_ready,
  output logic [8*LANES-1:0]   tx_data,
  output logic [LANES-1:0]     tx_k,
  output logic                 tx_valid,
  input  logic                 rx_valid,
  input  logic [8*LANES-1:0]   rx_data,
  input  logic [LANES-1:0]     rx_k,
  input  logic [LANES-1:0]     rx_code_err,
  input  logic [LANES-1:0]     rx_disp_err,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int DW = 8 * LANES;
  localparam int AW = $clog2(ALIGN_LEN + 1);
  localparam int PW = $clog2(COMMA_PERIOD + 1);
  localparam int CW = $clog2(LOSS_THRESH + 1);
  localparam logic [14:0]   SEED       = 15'h7FFF;
  localparam logic [DW-1:0] COMMA_WORD = {LANES{8'hBC}};

  typedef enum logic [1:0] {G_IDLE, G_ALIGN, G_DATA} gen_state_t;
  typedef enum logic {C_SEARCH, C_LOCKED} chk_state_t;

  // Returns {payload word, LFSR after DW steps}; the first generated bit is the word MSB.
  function automatic logic [DW+14:0] prbs_step(input logic [14:0] s);
    logic [DW-1:0] w;
    logic [14:0]   t;
    logic          nb;
    t = s;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      nb          = t[14] ^ t[13];
      w[DW-1-i]   = nb;
      t           = {t[13:0], nb};
    end
    return {w, t};
  endfunction

  // ---------------- generator ----------------
  gen_state_t      r_gen_state, w_gen_nxt;
  logic [14:0]     r_tx_lfsr, w_tx_lfsr_nxt;
  logic [AW-1:0]   r_align_cnt, w_align_nxt;
  logic [PW-1:0]   r_pay_cnt, w_pay_nxt;
  logic            r_tx_valid;
  logic [DW-1:0]   r_tx_data;
  logic [LANES-1:0] r_tx_k;

  logic            w_tx_acc, w_comma_due;
  logic [DW+14:0]  w_tx_step, w_nxt_step;
  logic            w_tx_valid_nxt, w_tx_comma_nxt;
  logic [DW-1:0]   w_tx_data_nxt;
  logic [LANES-1:0] w_tx_k_nxt;

  assign w_tx_acc    = r_tx_valid & tx_ready;
  assign w_comma_due = (r_pay_cnt == PW'(COMMA_PERIOD));
  assign w_tx_step   = prbs_step(r_tx_lfsr);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_gen_nxt     = r_gen_state;
    w_tx_lfsr_nxt = r_tx_lfsr;
    w_align_nxt   = r_align_cnt;
    w_pay_nxt     = r_pay_cnt;
    case (r_gen_state)
      G_IDLE: begin
        if (start) begin
          w_gen_nxt     = G_ALIGN;
          w_tx_lfsr_nxt = SEED;
          w_align_nxt   = '0;
          w_pay_nxt     = '0;
        end
      end
      G_ALIGN: begin
        if (w_tx_acc) begin
          if (r_align_cnt == AW'(ALIGN_LEN - 1)) begin
            w_gen_nxt   = G_DATA;
            w_align_nxt = '0;
          end else begin
            w_align_nxt = r_align_cnt + AW'(1);
          end
        end
      end
      G_DATA: begin
        if (w_tx_acc) begin
          if (w_comma_due) begin
            w_pay_nxt = '0;
          end else begin
            w_tx_lfsr_nxt = w_tx_step[14:0];
            w_pay_nxt     = r_pay_cnt + PW'(1);
          end
        end
      end
      default: w_gen_nxt = G_IDLE;
    endcase
    // A word accepted this cycle has already been booked above; dropping start just stops.
    if (r_gen_state != G_IDLE && !start) w_gen_nxt = G_IDLE;
  end

  // Port registers are loaded from the next state so the presented word always matches it.
  assign w_nxt_step     = prbs_step(w_tx_lfsr_nxt);
  assign w_tx_valid_nxt = (w_gen_nxt != G_IDLE);
  assign w_tx_comma_nxt = (w_gen_nxt == G_ALIGN) ||
                          (w_gen_nxt == G_DATA && w_pay_nxt == PW'(COMMA_PERIOD));
  assign w_tx_data_nxt  = !w_tx_valid_nxt ? '0 :
                          w_tx_comma_nxt  ? COMMA_WORD : w_nxt_step[DW+14:15];
  assign w_tx_k_nxt     = (w_tx_valid_nxt && w_tx_comma_nxt) ? '1 : '0;

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gen_state <= G_IDLE;
      r_tx_lfsr   <= SEED;
      r_align_cnt <= '0;
      r_pay_cnt   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_tx_k      <= '0;
    end else begin
      r_gen_state <= w_gen_nxt;
      r_tx_lfsr   <= w_tx_lfsr_nxt;
      r_align_cnt <= w_align_nxt;
      r_pay_cnt   <= w_pay_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_k      <= w_tx_k_nxt;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign tx_k     = r_tx_k;

  // ---------------- checker ----------------
  chk_state_t      r_chk_state, w_chk_nxt;
  logic [14:0]     r_rx_lfsr, w_rx_lfsr_nxt;
  logic            r_seen_comma, w_seen_nxt;
  logic [CW-1:0]   r_consec, w_consec_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_nxt;
  logic [CNT_W-1:0] r_word_cnt, w_word_nxt;
  logic            r_locked;

  logic            w_full_comma, w_flag_err, w_clean_comma, w_bad, w_count;
  logic [DW+14:0]  w_rx_step;

  assign w_rx_step     = prbs_step(r_rx_lfsr);
  assign w_full_comma  = (&rx_k) && (rx_data == COMMA_WORD);
  assign w_flag_err    = (|rx_code_err) || (|rx_disp_err);
  assign w_clean_comma = w_full_comma && !w_flag_err;
  assign w_bad         = w_flag_err || ((|rx_k) && !w_full_comma) ||
                         (!w_full_comma && rx_data != w_rx_step[DW+14:15]);

  always_comb begin
    w_chk_nxt     = r_chk_state;
    w_rx_lfsr_nxt = r_rx_lfsr;
    w_seen_nxt    = r_seen_comma;
    w_consec_nxt  = r_consec;
    w_err_nxt     = r_err_cnt;
    w_word_nxt    = r_word_cnt;
    w_count       = 1'b0;
    if (rx_valid) begin
      if (r_chk_state == C_SEARCH) begin
        if (w_clean_comma) begin
          w_seen_nxt    = 1'b1;
          w_rx_lfsr_nxt = SEED;
        end else if (rx_k == '0 && r_seen_comma) begin
          w_seen_nxt = 1'b0;
          w_chk_nxt  = C_LOCKED;
          w_count    = 1'b1;
        end else begin
          w_seen_nxt = 1'b0;
        end
      end else begin
        w_count = 1'b1;
      end
    end
    if (w_count) begin
      if (!w_full_comma) begin
        w_rx_lfsr_nxt = w_rx_step[14:0];
        if (r_word_cnt != '1) w_word_nxt = r_word_cnt + CNT_W'(1);
      end
      if (w_bad) begin
        if (r_err_cnt != '1) w_err_nxt = r_err_cnt + CNT_W'(1);
        if (r_consec == CW'(LOSS_THRESH - 1) && !clr_cnt) begin
          w_chk_nxt    = C_SEARCH;
          w_seen_nxt   = 1'b0;
          w_consec_nxt = '0;
        end else begin
          w_consec_nxt = r_consec + CW'(1);
        end
      end else begin
        w_consec_nxt = '0;
      end
    end
    if (clr_cnt) begin
      w_err_nxt    = '0;
      w_word_nxt   = '0;
      w_consec_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chk_state  <= C_SEARCH;
      r_rx_lfsr    <= SEED;
      r_seen_comma <= 1'b0;
      r_consec     <= '0;
      r_err_cnt    <= '0;
      r_word_cnt   <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_chk_state  <= w_chk_nxt;
      r_rx_lfsr    <= w_rx_lfsr_nxt;
      r_seen_comma <= w_seen_nxt;
      r_consec     <= w_consec_nxt;
      r_err_cnt    <= w_err_nxt;
      r_word_cnt   <= w_word_nxt;
      r_locked     <= (r_chk_state == C_LOCKED);
    end
  end

  assign locked   = r_locked;
  assign err_cnt  = r_err_cnt;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_link_bist_16b20b.sv
// Self-checking bench: generator looped back to checker with random backpressure and
// error injection, plus a 4-bit-counter instance driven directly for saturation/clear.
module tb_link_bist_16b20b;

  localparam int NB = 16 * 1200 + 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [15:0] inj_mask = '0;
  logic [1:0]  inj_disp = '0;

  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic        tx_valid;
  logic        locked;
  logic [15:0] err_cnt, word_cnt;
  logic        rx_valid;
  logic [15:0] rx_data;

  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [1:0]  s_k = '0;
  logic        s_clr = 1'b0;
  logic [15:0] s_tx_data;
  logic [1:0]  s_tx_k;
  logic        s_tx_valid;
  logic        s_locked;
  logic [3:0]  s_err, s_word;

  int n_checks = 0;
  int n_fail   = 0;

  bit          e [0:NB-1];
  logic [17:0] q [$];
  int          n_pay = 0;
  logic        hold_pending = 1'b0;
  logic [17:0] held = '0;

  always #5 clk = ~clk;

  assign rx_valid = tx_valid & tx_ready;
  assign rx_data  = tx_data ^ inj_mask;

  link_bist_16b20b u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_k(tx_k), .tx_valid(tx_valid),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_k(tx_k),
    .rx_code_err(2'b00), .rx_disp_err(inj_disp),
    .clr_cnt(clr_cnt), .locked(locked), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  link_bist_16b20b #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(1'b0), .tx_ready(1'b0),
    .tx_data(s_tx_data), .tx_k(s_tx_k), .tx_valid(s_tx_valid),
    .rx_valid(s_valid), .rx_data(s_data), .rx_k(s_k),
    .rx_code_err(2'b00), .rx_disp_err(2'b00),
    .clr_cnt(s_clr), .locked(s_locked), .err_cnt(s_err), .word_cnt(s_word)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // PRBS payload word j: bit stream b[n] = b[n-15] ^ b[n-14], 15 leading ones as the seed.
  function automatic logic [15:0] prbs_word(input int j);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = e[15 + 16*j + i];
    return w;
  endfunction

  // Expected {k, data} of the idx-th accepted word after start.
  function automatic logic [17:0] exp_item(input int idx);
    int p, r;
    if (idx < 16) return {2'b11, 16'hBCBC};
    p = idx - 16;
    r = p % 65;
    if (r == 64) return {2'b11, 16'hBCBC};
    return {2'b00, prbs_word((p / 65) * 64 + r)};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (hold_pending && tx_valid) chk("hold_stable", {14'd0, tx_k, tx_data}, {14'd0, held});
    hold_pending = tx_valid && !tx_ready && start;
    held = {tx_k, tx_data};
    if (tx_valid && tx_ready) begin
      q.push_back({tx_k, tx_data});
      if (tx_k == 2'b00) n_pay++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_stream();
    for (int i = 0; i < q.size(); i++)
      chk("stream", {14'd0, q[i]}, {14'd0, exp_item(i)});
  endtask

  task automatic inject(input logic [15:0] m, input logic [1:0] d);
    int guard = 0;
    tx_ready = 1'b1;
    while (!(tx_valid && tx_k == 2'b00) && guard < 200) begin
      tick();
      guard++;
    end
    chk("inject_wait", {31'd0, guard < 200}, 32'd1);
    inj_mask = m;
    inj_disp = d;
    tick();
    inj_mask = '0;
    inj_disp = '0;
  endtask

  task automatic sat_word(input logic [15:0] d, input logic [1:0] k);
    s_valid = 1'b1;
    s_data  = d;
    s_k     = k;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int j;
    for (int m = 0; m < 15; m++) e[m] = 1'b1;
    for (int m = 15; m < NB; m++) e[m] = e[m-15] ^ e[m-14];

    // Reset and idle
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("idle_locked", {31'd0, locked}, 32'd0);
    chk("idle_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("idle_word_cnt", {16'd0, word_cnt}, 32'd0);

    // Alignment preamble and first payload word
    start = 1'b1;
    tx_ready = 1'b1;
    guard = 0;
    while (q.size() < 17 && guard < 100) begin tick(); guard++; end
    tx_ready = 1'b0;
    chk("align_words", q.size(), 32'd17);
    compare_stream();
    chk("first_payload", {14'd0, q[16]}, {14'd0, 2'b00, 16'h0002});
    repeat (2) tick();
    chk("lock_after_align", {31'd0, locked}, 32'd1);
    chk("err_after_align", {16'd0, err_cnt}, 32'd0);
    chk("word_after_align", {16'd0, word_cnt}, 32'd1);

    // Random backpressure over 200 payload words with comma insertion
    guard = 0;
    while (n_pay < 200 && guard < 3000) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    tx_ready = 1'b0;
    repeat (2) tick();
    chk("bp_total_words", q.size(), 32'd219);
    compare_stream();
    chk("bp_word_cnt", {16'd0, word_cnt}, 32'd200);
    chk("bp_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("bp_locked", {31'd0, locked}, 32'd1);

    // Single-bit data error and a disparity error
    inject(16'h0001, 2'b00);
    tx_ready = 1'b0;
    repeat (2) tick();
    chk("inj_bit_err", {16'd0, err_cnt}, 32'd1);
    chk("inj_bit_locked", {31'd0, locked}, 32'd1);
    inject(16'h0000, 2'b10);
    tx_ready = 1'b0;
    repeat (2) tick();
    chk("inj_disp_err", {16'd0, err_cnt}, 32'd2);
    chk("inj_disp_locked", {31'd0, locked}, 32'd1);

    // Clear, then four consecutive bad payload words drop lock
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_err", {16'd0, err_cnt}, 32'd0);
    chk("clr_word", {16'd0, word_cnt}, 32'd0);
    tx_ready = 1'b1;
    guard = 0;
    while (((q.size() - 16) % 65) > 60 && guard < 100) begin tick(); guard++; end
    for (int i = 0; i < 4; i++) inject(16'h8000 >> i, 2'b00);
    tx_ready = 1'b0;
    repeat (2) tick();
    chk("loss_locked", {31'd0, locked}, 32'd0);
    chk("loss_err", {16'd0, err_cnt}, 32'd4);
    chk("loss_word", {16'd0, word_cnt}, 32'd4);
    compare_stream();

    // Realign and relock with no further errors
    start = 1'b0;
    repeat (2) tick();
    chk("realign_idle", {31'd0, tx_valid}, 32'd0);
    q.delete();
    n_pay = 0;
    start = 1'b1;
    tx_ready = 1'b1;
    guard = 0;
    while (q.size() < 40 && guard < 200) begin tick(); guard++; end
    tx_ready = 1'b0;
    repeat (2) tick();
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_err", {16'd0, err_cnt}, 32'd4);
    chk("relock_word", {16'd0, word_cnt}, 32'd28);
    compare_stream();

    // Saturation and clear on the 4-bit counter instance
    sat_word(16'hBCBC, 2'b11);
    j = 0;
    for (int i = 0; i < 20; i++) begin
      sat_word(prbs_word(j), 2'b00);
      sat_word(prbs_word(j + 1) ^ 16'h0001, 2'b00);
      j += 2;
    end
    repeat (2) tick();
    chk("sat_err", {28'd0, s_err}, 32'hF);
    chk("sat_word", {28'd0, s_word}, 32'hF);
    chk("sat_locked", {31'd0, s_locked}, 32'd1);
    s_clr = 1'b1;
    sat_word(prbs_word(j) ^ 16'h0001, 2'b00);
    s_clr = 1'b0;
    chk("sat_clr_err", {28'd0, s_err}, 32'd0);
    chk("sat_clr_word", {28'd0, s_word}, 32'd0);

    // Asynchronous reset in the middle of payload
    tx_ready = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {16'd0, tx_data}, 32'd0);
    chk("rst_tx_k", {30'd0, tx_k}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {16'd0, err_cnt}, 32'd0);
    chk("rst_word", {16'd0, word_cnt}, 32'd0);
    rst = 1'b1;
    tx_ready = 1'b0;
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
